tick_task_scheduler: RTL and testbench

// Derives a periodic scheduling tick from the 1 kHz system clock (default 100 Hz).

---
 rtl/tick_task_scheduler_if.sv | 41 ++++
 rtl/tick_task_scheduler.sv | 169 ++++++++++++++++
 tb/tb_tick_task_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_task_scheduler_if.sv
// Bundles the control inputs and status outputs of tick_task_scheduler.
//   master : drives en, div_load, div_val, task_done, err_clr; observes status
//   slave  : the scheduler; drives tick, task_start, cur_task, busy,
//            overrun, timeout_err
// Port summary (NTASK = number of sequenced tasks):
//   en           1      divider enable
//   div_load     1      strobe: capture div_val into the shadow divisor
//   div_val      8      new divisor (0 and 1 clamp to 2)
//   task_done    NTASK  per-task done (only the current task's bit counts)
//   err_clr      1      clears overrun and timeout_err
//   tick         1      1-cycle pulse on divider wrap
//   task_start   NTASK  one-hot 1-cycle start pulse
//   cur_task     3      index of the task being serviced
//   busy         1      frame in progress
//   overrun      1      sticky: tick arrived while busy
//   timeout_err  NTASK  sticky per-task timeout flags
interface tick_task_scheduler_if #(
    parameter int NTASK = 3
);
    logic             en;
    logic             div_load;
    logic [7:0]       div_val;
    logic [NTASK-1:0] task_done;
    logic             err_clr;
    logic             tick;
    logic [NTASK-1:0] task_start;
    logic [2:0]       cur_task;
    logic             busy;
    logic             overrun;
    logic [NTASK-1:0] timeout_err;

    modport master (
        output en, div_load, div_val, task_done, err_clr,
        input  tick, task_start, cur_task, busy, overrun, timeout_err
    );

    modport slave (
        input  en, div_load, div_val, task_done, err_clr,
        output tick, task_start, cur_task, busy, overrun, timeout_err
    );
endinterface

// File: rtl/tick_task_scheduler.sv
// Periodic task scheduler for the flood monitor.
// A programmable divider turns the 1 kHz clock into a scheduling tick; each
// accepted tick runs one frame that starts NTASK tasks in fixed order using a
// start/done handshake with a per-task timeout.
// Ports:
//   clk    system clock (1 kHz)
//   rst_n  asynchronous active-low reset
//   bus    tick_task_scheduler_if.slave (control inputs, status outputs)
// Parameters:
//   DIV      reset divisor (2..255)
//   NTASK    number of tasks (1..8)
//   TIMEOUT  max WAIT cycles per task (1..255)
module tick_task_scheduler #(
    parameter int DIV     = 10,
    parameter int NTASK   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tick_task_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        NEXT
    } state_t;

    localparam logic [7:0] DIV_INIT     = 8'(DIV);
    localparam logic [7:0] TIMEOUT_INIT = 8'(TIMEOUT);
    localparam logic [2:0] LAST_TASK    = 3'(NTASK - 1);

    logic [7:0]       cnt;
    logic [7:0]       div_act;
    logic [7:0]       div_shadow;
    logic [7:0]       div_clamped;
    logic             tick_q;
    logic             wrap;

    state_t           state;
    state_t           state_next;
    logic [2:0]       cur_task_q;
    logic [2:0]       cur_task_next;
    logic [7:0]       timer;
    logic [7:0]       timer_next;
    logic             done_cur;
    logic [NTASK-1:0] err_q;
    logic [NTASK-1:0] err_set;
    logic [NTASK-1:0] start_vec;
    logic             overrun_q;
    logic             overrun_set;

    assign div_clamped = (bus.div_val < 8'd2) ? 8'd2 : bus.div_val;
    assign wrap        = bus.en && (cnt == div_act - 8'd1);

    // Divider. A load on the wrap edge itself is the last load before the
    // wrap, so it bypasses the shadow and takes effect for the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            tick_q     <= 1'b0;
            div_act    <= DIV_INIT;
            div_shadow <= DIV_INIT;
        end else begin
            if (bus.div_load) begin
                div_shadow <= div_clamped;
            end
            if (!bus.en) begin
                cnt    <= '0;
                tick_q <= 1'b0;
            end else if (wrap) begin
                cnt     <= '0;
                tick_q  <= 1'b1;
                div_act <= bus.div_load ? div_clamped : div_shadow;
            end else begin
                cnt    <= cnt + 8'd1;
                tick_q <= 1'b0;
            end
        end
    end

    // Select the current task's done bit and decode the start pulse.
    always_comb begin
        done_cur  = 1'b0;
        start_vec = '0;
        for (int i = 0; i < NTASK; i++) begin
            if (cur_task_q == 3'(i)) begin
                done_cur     = bus.task_done[i];
                start_vec[i] = (state == START);
            end
        end
    end

    // Frame sequencer next-state logic.
    always_comb begin
        state_next    = state;
        cur_task_next = cur_task_q;
        timer_next    = timer;
        err_set       = '0;
        overrun_set   = 1'b0;
        case (state)
            IDLE: begin
                if (tick_q) begin
                    state_next    = START;
                    cur_task_next = '0;
                end
            end
            START: begin
                timer_next = TIMEOUT_INIT;
                state_next = WAIT;
            end
            WAIT: begin
                // done is checked first so it wins over a same-cycle expiry
                if (done_cur) begin
                    state_next = NEXT;
                end else if (timer == 8'd1) begin
                    for (int i = 0; i < NTASK; i++) begin
                        if (cur_task_q == 3'(i)) begin
                            err_set[i] = 1'b1;
                        end
                    end
                    state_next = NEXT;
                end else begin
                    timer_next = timer - 8'd1;
                end
            end
            NEXT: begin
                if (cur_task_q == LAST_TASK) begin
                    state_next    = IDLE;
                    cur_task_next = '0;
                end else begin
                    state_next    = START;
                    cur_task_next = cur_task_q + 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Ticks are never queued: any tick outside IDLE is dropped and flagged.
        if (tick_q && (state != IDLE)) begin
            overrun_set = 1'b1;
        end
    end

    // Sequencer state and sticky flags; a same-cycle set beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_task_q <= '0;
            timer      <= '0;
            overrun_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state      <= state_next;
            cur_task_q <= cur_task_next;
            timer      <= timer_next;
            overrun_q  <= overrun_set | (overrun_q & ~bus.err_clr);
            err_q      <= err_set | (err_q & ~{NTASK{bus.err_clr}});
        end
    end

    assign bus.tick        = tick_q;
    assign bus.task_start  = start_vec;
    assign bus.cur_task    = cur_task_q;
    assign bus.busy        = (state != IDLE);
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_tick_task_scheduler.sv
// Testbench for tick_task_scheduler.
// A reference model predicts tick times from the divisor rules and lays out
// each accepted frame as a schedule of start cycles computed from the task
// response latencies; the bench drives task_done from that schedule.
module tb_tick_task_scheduler;
    localparam int DIV     = 10;
    localparam int NTASK   = 3;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n;

    tick_task_scheduler_if #(.NTASK(NTASK)) bus ();

    tick_task_scheduler #(
        .DIV     (DIV),
        .NTASK   (NTASK),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int passed;
    int failed;
    int total;

    // reference model state
    int               cyc;
    int               act_p;
    int               pend_p;
    int               next_tick;
    bit               en_prev;
    bit               frame_on;
    int               frame_t;
    int               idle_at;
    int               s_arr   [NTASK];
    int               k_arr   [NTASK];
    int               lat_arr [NTASK];
    int               lat_cfg [NTASK];
    bit               lat_random;
    logic [NTASK-1:0] m_err;
    logic             m_ovr;

    function automatic bit latValid(input int l);
        return (l >= 1) && (l <= TIMEOUT);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_tick"},        32'(bus.tick),        32'd0);
        checkOutput({tag, "_task_start"},  32'(bus.task_start),  32'd0);
        checkOutput({tag, "_cur_task"},    32'(bus.cur_task),    32'd0);
        checkOutput({tag, "_busy"},        32'(bus.busy),        32'd0);
        checkOutput({tag, "_overrun"},     32'(bus.overrun),     32'd0);
        checkOutput({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
    endtask

    task automatic modelReset();
        cyc       = 0;
        act_p     = DIV;
        pend_p    = DIV;
        next_tick = -1;
        en_prev   = 1'b0;
        frame_on  = 1'b0;
        frame_t   = 0;
        idle_at   = 0;
        m_err     = '0;
        m_ovr     = 1'b0;
    endtask

    // Lay out a whole frame: task i occupies START + k_i WAIT + NEXT cycles.
    task automatic startFrame(input int t);
        int s;
        s = t + 1;
        for (int i = 0; i < NTASK; i++) begin
            lat_arr[i] = lat_random ? int'($urandom_range(0, TIMEOUT)) : lat_cfg[i];
            k_arr[i]   = latValid(lat_arr[i]) ? lat_arr[i] : TIMEOUT;
            s_arr[i]   = s;
            s          = s + k_arr[i] + 2;
        end
        idle_at  = s;
        frame_t  = t;
        frame_on = 1'b1;
    endtask

    // Called just after a rising edge: drives one cycle, checks it mid-cycle,
    // then advances the model to the next cycle.
    task automatic applyStimulus(input bit en_v, input bit load_v, input logic [7:0] val_v,
                                 input bit clr_v, input bit noise_v);
        logic [NTASK-1:0] done_v;
        logic [NTASK-1:0] exp_start;
        bit               exp_tick;
        bit               exp_busy;
        int               exp_cur;
        done_v = '0;
        for (int j = 0; j < NTASK; j++) begin
            if (frame_on && cyc >= s_arr[j] && cyc <= s_arr[j] + k_arr[j] + 1) begin
                if (latValid(lat_arr[j]) && cyc == s_arr[j] + lat_arr[j])
                    done_v[j] = 1'b1;
                else if (noise_v && (cyc == s_arr[j] || cyc == s_arr[j] + k_arr[j] + 1))
                    done_v[j] = 1'($urandom_range(0, 1));
            end else if (noise_v) begin
                done_v[j] = 1'($urandom_range(0, 1));
            end
        end
        bus.en        = en_v;
        bus.div_load  = load_v;
        bus.div_val   = val_v;
        bus.err_clr   = clr_v;
        bus.task_done = done_v;

        exp_tick  = (next_tick == cyc);
        exp_busy  = frame_on && (cyc > frame_t) && (cyc < idle_at);
        exp_start = '0;
        exp_cur   = 0;
        for (int j = 0; j < NTASK; j++) begin
            if (frame_on && cyc >= s_arr[j] && cyc <= s_arr[j] + k_arr[j] + 1) begin
                exp_cur = j;
                if (cyc == s_arr[j]) exp_start[j] = 1'b1;
            end
        end

        @(negedge clk);
        checkOutput("tick",        32'(bus.tick),        32'(exp_tick));
        checkOutput("task_start",  32'(bus.task_start),  32'(exp_start));
        checkOutput("cur_task",    32'(bus.cur_task),    32'(exp_cur));
        checkOutput("busy",        32'(bus.busy),        32'(exp_busy));
        checkOutput("overrun",     32'(bus.overrun),     32'(m_ovr));
        checkOutput("timeout_err", 32'(bus.timeout_err), 32'(m_err));

        if (clr_v) begin
            m_err = '0;
            m_ovr = 1'b0;
        end
        for (int j = 0; j < NTASK; j++) begin
            if (frame_on && !latValid(lat_arr[j]) && cyc == s_arr[j] + TIMEOUT)
                m_err[j] = 1'b1;
        end
        if (exp_tick && exp_busy) m_ovr = 1'b1;
        if (exp_tick && !exp_busy) startFrame(cyc);

        if (exp_tick) begin
            act_p     = pend_p;
            next_tick = cyc + act_p;
        end
        if (load_v) pend_p = (val_v < 8'd2) ? 2 : int'(val_v);
        if (!en_v) next_tick = -1;
        else if (!en_prev) next_tick = cyc + act_p;
        en_prev = en_v;

        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        passed        = 0;
        failed        = 0;
        total         = 0;
        lat_random    = 1'b0;
        lat_cfg       = '{2, 2, 2};
        rst_n         = 1'b0;
        bus.en        = 1'b1;
        bus.div_load  = 1'b0;
        bus.div_val   = 8'd0;
        bus.task_done = '0;
        bus.err_clr   = 1'b0;
        modelReset();
        #1;
        checkZero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();

        // Tasks answer 2 clks after start.
        repeat (45) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

        // Task 1 never answers; then clear the sticky flags.
        lat_cfg = '{2, 0, 2};
        repeat (45) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        lat_cfg = '{2, 2, 2};
        repeat (25) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

        // Done exactly at expiry, with noise on other bits.
        lat_cfg = '{TIMEOUT, 3, TIMEOUT};
        repeat (50) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);

        // Divisor reprogramming.
        lat_cfg = '{1, 1, 1};
        repeat (3) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd20, 1'b0, 1'b0);
        repeat (60) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        repeat (25) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd30, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd12, 1'b0, 1'b0);
        repeat (40) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd10, 1'b0, 1'b0);
        repeat (30) applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);

        // Frame of 18 clks against a 10-clk period.
        lat_cfg = '{4, 4, 4};
        repeat (50) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

        // Divider disabled while a frame is running.
        lat_cfg = '{2, 2, 2};
        repeat (15) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        repeat (30) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

        // Randomized traffic.
        lat_random = 1'b1;
        repeat (400) begin
            applyStimulus(1'($urandom_range(0, 19) != 0),
                          1'($urandom_range(0, 14) == 0),
                          8'($urandom_range(0, 24)),
                          1'($urandom_range(0, 11) == 0),
                          1'b1);
        end
        lat_random = 1'b0;

        // Reset while task 1 is waiting.
        lat_cfg = '{2, 6, 2};
        found   = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (frame_on && cyc >= s_arr[1] + 2 && cyc <= s_arr[1] + k_arr[1])
                found = 1'b1;
            else
                applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        end
        checkOutput("reach_task1_wait", 32'(found), 32'd1);
        if (found) begin
            rst_n         = 1'b0;
            bus.task_done = '0;
            #1;
            checkZero("midreset");
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            modelReset();
            lat_cfg = '{2, 2, 2};
            repeat (30) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
